// File: rtl/craft_rng_pkg.sv
// Shared types for the PRNG jitter path.
// Pair format and raw-to-signed jitter conversion.
package craft_rng_pkg;

    localparam int JITTER_W = 12;

    typedef logic signed [JITTER_W-1:0] jitter_t;

    typedef struct packed {
        jitter_t x;
        jitter_t y;
    } jitter_pair_t;

    // Inverting the MSB recentres an unsigned draw: r - 2048.
    function automatic jitter_t to_jitter(input logic [11:0] r);
        return jitter_t'({~r[11], r[10:0]});
    endfunction

endpackage

// File: rtl/jitter_pair_fifo.sv
// Synchronous FIFO of jitter pairs.
// Supports push, pop, clear, count, full and empty.
module jitter_pair_fifo
    import craft_rng_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         push,
    input  logic         pop,
    input  jitter_pair_t din,
    output jitter_pair_t dout,
    output logic [4:0]   count,
    output logic         full,
    output logic         empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    jitter_pair_t mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == 5'(DEPTH));
    assign empty   = (count == 5'd0);
    assign do_push = push && !full && !clear;
    assign do_pop  = pop && !empty && !clear;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 5'd1;
                2'b01:   count <= count - 5'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/prng_jitter_buffer.sv
// Consumes xorshift PRNG draws, pairs them into signed (x,y)
// sub-pixel offsets and serves them over valid/ready.
module prng_jitter_buffer
    import craft_rng_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int WARMUP = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        flush,
    output logic        prng_en,
    input  logic [11:0] prng_rand_num,
    output logic        jitter_valid,
    input  logic        jitter_ready,
    output logic [11:0] jitter_x,
    output logic [11:0] jitter_y,
    output logic [4:0]  fill_level
);

    localparam logic [0:0] ST_WARMUP = 1'b0;
    localparam logic [0:0] ST_RUN    = 1'b1;
    localparam logic [7:0] WARM_INIT = 8'(WARMUP);

    logic [0:0]   state;
    logic [7:0]   warm_cnt;
    logic         half_valid;
    jitter_t      x_hold;
    jitter_pair_t head;
    jitter_pair_t new_pair;
    logic [4:0]   count;
    logic         full;
    logic         empty;
    logic         run;
    logic         capture;
    logic         push;
    logic         pop;

    assign run      = (state == ST_RUN);
    assign prng_en  = !rst && !flush && enable && (!run || !full);
    assign capture  = prng_en && run;
    assign push     = capture && half_valid;
    assign new_pair = '{x: x_hold, y: to_jitter(prng_rand_num)};

    assign jitter_valid = !rst && !empty;
    assign pop          = jitter_valid && jitter_ready && !flush;
    assign jitter_x     = jitter_valid ? head.x : '0;
    assign jitter_y     = jitter_valid ? head.y : '0;
    assign fill_level   = rst ? 5'd0 : count;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= (WARMUP == 0) ? ST_RUN : ST_WARMUP;
            warm_cnt   <= WARM_INIT;
            half_valid <= 1'b0;
            x_hold     <= '0;
        end else begin
            if (prng_en && !run) begin
                warm_cnt <= warm_cnt - 8'd1;
                if (warm_cnt <= 8'd1) begin
                    state <= ST_RUN;
                end
            end
            // A flush cycle never captures, so dropping the half pair is safe.
            if (flush) begin
                half_valid <= 1'b0;
            end else if (capture) begin
                if (!half_valid) begin
                    x_hold <= to_jitter(prng_rand_num);
                end
                half_valid <= !half_valid;
            end
        end
    end

    jitter_pair_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (flush),
        .push  (push),
        .pop   (pop),
        .din   (new_pair),
        .dout  (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

endmodule

// File: tb/tb_prng_jitter_buffer.sv
// Directed bench for prng_jitter_buffer with a reference
// 16-bit xorshift PRNG (seed 16'h1ACE) driving rand_num.
module tb_prng_jitter_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        flush;
    logic        prng_en;
    logic [11:0] prng_rand_num;
    logic        jitter_valid;
    logic        jitter_ready;
    logic [11:0] jitter_x;
    logic [11:0] jitter_y;
    logic [4:0]  fill_level;

    int checks = 0;
    int errors = 0;

    logic [11:0] seq [128];
    int          idx = 0;
    logic        force_on = 1'b0;
    logic [11:0] fval = 12'h000;
    int          base;
    int          b2;

    int fl_exp [6] = '{4, 3, 2, 2, 1, 1};
    int pe_exp [6] = '{0, 1, 1, 1, 1, 1};

    always #5 clk = ~clk;

    prng_jitter_buffer #(
        .DEPTH(4),
        .WARMUP(4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .flush         (flush),
        .prng_en       (prng_en),
        .prng_rand_num (prng_rand_num),
        .jitter_valid  (jitter_valid),
        .jitter_ready  (jitter_ready),
        .jitter_x      (jitter_x),
        .jitter_y      (jitter_y),
        .fill_level    (fill_level)
    );

    function automatic logic [15:0] xs(input logic [15:0] s);
        logic [15:0] t;
        t = s ^ (s << 7);
        t = t ^ (t >> 9);
        t = t ^ (t << 8);
        return t;
    endfunction

    function automatic logic [11:0] cv(input logic [11:0] r);
        return {~r[11], r[10:0]};
    endfunction

    assign prng_rand_num = force_on ? fval : seq[idx % 128];

    always @(posedge clk) begin
        if (prng_en) begin
            idx <= idx + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] s;
        s = 16'h1ACE;
        for (int i = 0; i < 128; i++) begin
            seq[i] = s[11:0];
            s = xs(s);
        end

        rst = 1'b1;
        enable = 1'b1;
        flush = 1'b0;
        jitter_ready = 1'b0;
        nxt();
        nxt();
        #1;
        chk("rst_prng_en", 32'(prng_en), 0);
        chk("rst_valid", 32'(jitter_valid), 0);
        chk("rst_fill", 32'(fill_level), 0);
        chk("rst_x", 32'(jitter_x), 0);
        nxt();

        rst = 1'b0;
        base = idx;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("warm_en", 32'(prng_en), 1);
            chk("warm_valid", 32'(jitter_valid), 0);
            nxt();
        end
        chk("warm_idx", 32'(idx - base), 4);
        nxt();
        nxt();
        #1;
        chk("first_valid", 32'(jitter_valid), 1);
        chk("first_fill", 32'(fill_level), 1);
        chk("first_x", 32'(jitter_x), 32'(cv(seq[base + 4])));
        chk("first_y", 32'(jitter_y), 32'(cv(seq[base + 5])));

        repeat (6) nxt();
        chk("full_fill", 32'(fill_level), 4);
        chk("full_en", 32'(prng_en), 0);
        chk("full_idx", 32'(idx - base), 12);
        repeat (3) nxt();
        chk("hold_fill", 32'(fill_level), 4);
        chk("hold_idx", 32'(idx - base), 12);
        chk("hold_x", 32'(jitter_x), 32'(cv(seq[base + 4])));
        chk("hold_y", 32'(jitter_y), 32'(cv(seq[base + 5])));

        jitter_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #1;
            chk("drain_x", 32'(jitter_x), 32'(cv(seq[base + 4 + 2 * k])));
            chk("drain_y", 32'(jitter_y), 32'(cv(seq[base + 5 + 2 * k])));
            chk("drain_fill", 32'(fill_level), 32'(fl_exp[k]));
            chk("drain_en", 32'(prng_en), 32'(pe_exp[k]));
            if (k < 5) begin
                nxt();
            end
        end

        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(jitter_valid), 0);
        chk("mid_rst_en", 32'(prng_en), 0);
        nxt();
        rst = 1'b0;
        jitter_ready = 1'b0;
        b2 = idx;
        #1;
        chk("post_rst_valid", 32'(jitter_valid), 0);
        chk("post_rst_fill", 32'(fill_level), 0);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("rewarm_en", 32'(prng_en), 1);
            chk("rewarm_valid", 32'(jitter_valid), 0);
            nxt();
        end
        repeat (6) nxt();
        chk("pre_flush_fill", 32'(fill_level), 3);
        nxt();
        flush = 1'b1;
        #1;
        chk("flush_en", 32'(prng_en), 0);
        chk("flush_idx", 32'(idx - b2), 11);
        nxt();
        flush = 1'b0;
        #1;
        chk("post_flush_fill", 32'(fill_level), 0);
        chk("post_flush_valid", 32'(jitter_valid), 0);
        chk("post_flush_idx", 32'(idx - b2), 11);
        nxt();
        nxt();
        #1;
        chk("flush_pair_valid", 32'(jitter_valid), 1);
        chk("flush_pair_x", 32'(jitter_x), 32'(cv(seq[b2 + 11])));
        chk("flush_pair_y", 32'(jitter_y), 32'(cv(seq[b2 + 12])));
        nxt();

        enable = 1'b0;
        #1;
        chk("gap_en", 32'(prng_en), 0);
        nxt();
        nxt();
        enable = 1'b1;
        nxt();
        enable = 1'b0;
        jitter_ready = 1'b1;
        #1;
        chk("gap_fill", 32'(fill_level), 2);
        nxt();
        jitter_ready = 1'b0;
        #1;
        chk("gap_x", 32'(jitter_x), 32'(cv(seq[b2 + 13])));
        chk("gap_y", 32'(jitter_y), 32'(cv(seq[b2 + 14])));
        chk("gap_pop_fill", 32'(fill_level), 1);

        flush = 1'b1;
        enable = 1'b1;
        #1;
        chk("flush2_en", 32'(prng_en), 0);
        nxt();
        flush = 1'b0;
        force_on = 1'b1;
        fval = 12'h000;
        #1;
        chk("flush2_fill", 32'(fill_level), 0);
        nxt();
        fval = 12'h800;
        nxt();
        fval = 12'hFFF;
        #1;
        chk("conv_a_x", 32'(jitter_x), 32'h800);
        chk("conv_a_y", 32'(jitter_y), 32'h000);
        nxt();
        fval = 12'h000;
        nxt();
        enable = 1'b0;
        jitter_ready = 1'b1;
        nxt();
        #1;
        chk("conv_b_x", 32'(jitter_x), 32'h7FF);
        chk("conv_b_y", 32'(jitter_y), 32'h800);
        chk("conv_b_fill", 32'(fill_level), 1);
        nxt();
        chk("empty_valid", 32'(jitter_valid), 0);
        chk("empty_fill", 32'(fill_level), 0);
        chk("empty_x", 32'(jitter_x), 0);
        nxt();
        chk("underflow_fill", 32'(fill_level), 0);
        chk("underflow_valid", 32'(jitter_valid), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
